// File: rtl/cpu_mem_bridge_if.sv
// CPU-side request signals and controller-side request/handshake signals of
// cpu_mem_bridge. The shared cpu_rw_data bus stays a plain module inout so
// that its tristate resolution happens on a single net.
//
// Handshake: the CPU holds mem_rd/mem_wr (and addr/data) as a level while
// stall=1; mem_valid is a one-cycle completion pulse. Toward the controller,
// cpu_rw[1] is the request valid, held stable together with cpu_rw_addr
// until cpu_rw_vld acts as the one-cycle "done / read data valid" ready.
interface cpu_mem_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic [DATA_W-1:0] mem_rd_data;
  logic              mem_valid;
  logic              stall;
  logic              bus_err;
  logic [ADDR_W-1:0] cpu_rw_addr;
  logic [1:0]        cpu_rw;
  logic              cpu_rw_vld;

  // Bridge view.
  modport slave (
    input  mem_rd, mem_wr, mem_addr, mem_wr_data, cpu_rw_vld,
    output mem_rd_data, mem_valid, stall, bus_err, cpu_rw_addr, cpu_rw
  );

  // CPU + memory controller view.
  modport master (
    output mem_rd, mem_wr, mem_addr, mem_wr_data, cpu_rw_vld,
    input  mem_rd_data, mem_valid, stall, bus_err, cpu_rw_addr, cpu_rw
  );
endinterface

// File: rtl/cpu_mem_bridge.sv
// Bridge between the CPU memory stage and the memory controller CPU port.
// Registers one load/store at a time, issues it on cpu_rw/cpu_rw_addr, drives
// the shared data bus for writes, stalls the CPU until cpu_rw_vld and aborts
// with a sticky bus_err after TMO_CYC WAIT cycles without a response.
module cpu_mem_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TMO_CYC = 255
) (
  input  logic                clk,
  input  logic                rst,
  cpu_mem_bridge_if.slave     bus,
  inout  wire  [DATA_W-1:0]   cpu_rw_data,
  output logic [1:0]          dbg_state_o,
  output logic                dbg_bus_oe_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Counter value on the last permitted WAIT cycle (counter is 0 in the first).
  localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              op_wr_q, op_wr_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              bus_err_q, bus_err_d;

  logic req_any;
  logic active;
  logic bus_oe;

  assign req_any = bus.mem_rd | bus.mem_wr;
  // Request is presented to the controller in REQ and held through WAIT.
  assign active  = (state_q == S_REQ) || (state_q == S_WAIT);
  assign bus_oe  = active && op_wr_q;

  // Next-state and datapath updates; write wins when both rd and wr are set.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    op_wr_d   = op_wr_q;
    cnt_d     = cnt_q;
    rd_data_d = rd_data_q;
    bus_err_d = bus_err_q;
    case (state_q)
      S_IDLE: begin
        if (req_any) begin
          addr_d  = bus.mem_addr;
          wdata_d = bus.mem_wr_data;
          op_wr_d = bus.mem_wr;
          cnt_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.cpu_rw_vld) begin
          if (!op_wr_q) begin
            rd_data_d = cpu_rw_data;
          end
          state_d = S_DONE;
        end else if (cnt_q == TMO_LAST) begin
          bus_err_d = 1'b1;
          rd_data_d = '0;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      op_wr_q   <= 1'b0;
      cnt_q     <= '0;
      rd_data_q <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      op_wr_q   <= op_wr_d;
      cnt_q     <= cnt_d;
      rd_data_q <= rd_data_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Outputs decoded from state; the request cycle in IDLE already stalls,
  // but a CPU still holding its request during reset must not see a stall.
  always_comb begin
    bus.cpu_rw      = active ? {1'b1, ~op_wr_q} : 2'b00;
    bus.cpu_rw_addr = addr_q;
    bus.mem_rd_data = rd_data_q;
    bus.bus_err     = bus_err_q;
    bus.mem_valid   = (state_q == S_DONE);
    if (state_q == S_IDLE) begin
      bus.stall = req_any & ~rst;
    end else begin
      bus.stall = (state_q != S_DONE);
    end
  end

  assign cpu_rw_data  = bus_oe ? wdata_q : {DATA_W{1'bz}};
  assign dbg_state_o  = state_q;
  assign dbg_bus_oe_o = bus_oe;

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Directed bench for cpu_mem_bridge. The reference model derives every
// cycle's expected outputs from access timing (request cycle, WAIT length,
// completion cycle) and keeps expected load results in a queue.
module tb_cpu_mem_bridge;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  cpu_mem_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();
  wire  [DW-1:0] cpu_rw_data;
  logic [1:0]    dbg_state;
  logic          dbg_oe;
  logic          ctrl_drv = 1'b0;
  logic [DW-1:0] ctrl_data = '0;

  assign cpu_rw_data = ctrl_drv ? ctrl_data : {DW{1'bz}};

  cpu_mem_bridge #(.ADDR_W(AW), .DATA_W(DW), .TMO_CYC(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus_if.slave),
    .cpu_rw_data  (cpu_rw_data),
    .dbg_state_o  (dbg_state),
    .dbg_bus_oe_o (dbg_oe)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;

  bit            a_active = 1'b0;
  bit            a_wr     = 1'b0;
  bit            a_to     = 1'b0;
  logic [AW-1:0] a_addr   = '0;
  logic [DW-1:0] a_wdata  = '0;
  logic [DW-1:0] a_rdata  = '0;
  int            a_delay  = 0;
  int            a_req    = 0;
  int            a_done   = 0;
  bit            spur     = 1'b0;

  logic [DW-1:0] m_rd  = '0;
  bit            m_err = 1'b0;
  logic [DW-1:0] exp_q[$];
  int            valid_cnt      = 0;
  int            last_valid_cyc = 0;
  int            last_req       = 0;

  task automatic chk1(string name, logic act, logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d: got %0b want %0b", name, cyc, act, exp);
    end
  endtask

  task automatic chk32(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  // Access latency from the rules: 1 cycle to REQ, k WAIT cycles, 1 DONE.
  function automatic int lat_of(int delay);
    if (delay == 0 || delay > TMO) return TMO + 2;
    return delay + 2;
  endfunction

  // ---------------- memory controller model ----------------
  // Answers in WAIT cycle number a_delay (1-based); spur injects stray vld.
  always @(posedge clk) begin
    #2;
    if (spur) begin
      bus_if.cpu_rw_vld = 1'b1;
      ctrl_drv          = 1'b1;
      ctrl_data         = 32'hDEADBEEF;
    end else if (a_active && a_delay != 0 && a_delay <= TMO &&
                 cyc == a_req + 1 + a_delay) begin
      bus_if.cpu_rw_vld = 1'b1;
      ctrl_drv          = !a_wr;
      ctrl_data         = a_rdata;
    end else begin
      bus_if.cpu_rw_vld = 1'b0;
      ctrl_drv          = 1'b0;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    bit exp_v;
    bit in_win;
    logic [1:0] exp_rw;
    if (rst) begin
      m_rd  = '0;
      m_err = 1'b0;
      chk1("rst_stall", bus_if.stall, 1'b0);
      chk1("rst_valid", bus_if.mem_valid, 1'b0);
      chk1("rst_bus_err", bus_if.bus_err, 1'b0);
      chk1("rst_oe", dbg_oe, 1'b0);
      chk32("rst_cpu_rw", 32'(bus_if.cpu_rw), 32'd0);
      chk32("rst_addr", bus_if.cpu_rw_addr, 32'd0);
      chk32("rst_rd_data", bus_if.mem_rd_data, 32'd0);
    end else begin
      exp_v  = a_active && cyc == a_done;
      in_win = a_active && cyc > a_req && cyc < a_done;
      exp_rw = in_win ? {1'b1, ~a_wr} : 2'b00;
      if (exp_v) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL exp_q_empty cyc=%0d: got empty want entry", cyc);
        end else begin
          m_rd = exp_q.pop_front();
        end
        if (a_to) m_err = 1'b1;
      end
      chk1("mem_valid", bus_if.mem_valid, exp_v);
      chk1("stall", bus_if.stall, a_active && cyc < a_done);
      chk32("cpu_rw", 32'(bus_if.cpu_rw), 32'(exp_rw));
      chk1("bus_oe", dbg_oe, in_win && a_wr);
      if (in_win) chk32("cpu_rw_addr", bus_if.cpu_rw_addr, a_addr);
      if (in_win && a_wr) chk32("bus_wdata", cpu_rw_data, a_wdata);
      chk32("mem_rd_data", bus_if.mem_rd_data, m_rd);
      chk1("bus_err", bus_if.bus_err, m_err);
      if (bus_if.mem_valid) begin
        valid_cnt++;
        last_valid_cyc = cyc;
      end
    end
  end

  // ---------------- driver ----------------
  // Called at posedge+1; returns at posedge+1 of the cycle after completion.
  task automatic do_access(bit rd, bit wr, logic [AW-1:0] addr,
                           logic [DW-1:0] wdata, logic [DW-1:0] rdata,
                           int delay);
    a_wr     = wr;
    a_addr   = addr;
    a_wdata  = wdata;
    a_rdata  = rdata;
    a_delay  = delay;
    a_to     = (delay == 0 || delay > TMO);
    a_req    = cyc;
    last_req = cyc;
    a_done   = cyc + lat_of(delay);
    a_active = 1'b1;
    if (a_to)    exp_q.push_back('0);
    else if (wr) exp_q.push_back(m_rd);
    else         exp_q.push_back(rdata);
    bus_if.mem_rd      = rd;
    bus_if.mem_wr      = wr;
    bus_if.mem_addr    = addr;
    bus_if.mem_wr_data = wdata;
    @(posedge clk); #1;
    // Inputs change after acceptance; the latched request must not follow.
    bus_if.mem_addr    = ~addr;
    bus_if.mem_wr_data = ~wdata;
    while (cyc <= a_done) begin
      @(posedge clk); #1;
    end
    a_active      = 1'b0;
    bus_if.mem_rd = 1'b0;
    bus_if.mem_wr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bus_if.mem_rd      = 1'b0;
    bus_if.mem_wr      = 1'b0;
    bus_if.mem_addr    = '0;
    bus_if.mem_wr_data = '0;
    bus_if.cpu_rw_vld  = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // 1: load, controller answers in the second WAIT cycle.
    do_access(1'b1, 1'b0, 32'h10, 32'h0, 32'hCAFEF00D, 2);
    chk32("t1_rd_data", bus_if.mem_rd_data, 32'hCAFEF00D);
    chk32("t1_latency", 32'(last_valid_cyc - last_req), 32'd4);

    // 2: store; read data must stay from the previous load.
    do_access(1'b0, 1'b1, 32'h20, 32'h12345678, 32'h0, 1);
    chk32("t2_rd_kept", bus_if.mem_rd_data, 32'hCAFEF00D);
    chk32("t2_latency", 32'(last_valid_cyc - last_req), 32'd3);

    // 3: back-to-back load, store, load with immediate vld.
    base = valid_cnt;
    do_access(1'b1, 1'b0, 32'h30, 32'h0, 32'h11112222, 1);
    do_access(1'b0, 1'b1, 32'h34, 32'h33334444, 32'h0, 1);
    do_access(1'b1, 1'b0, 32'h38, 32'h0, 32'h55556666, 1);
    chk32("t3_pulses", 32'(valid_cnt - base), 32'd3);
    chk32("t3_rd_data", bus_if.mem_rd_data, 32'h55556666);

    // 4: rd and wr together behave as a write.
    do_access(1'b1, 1'b1, 32'h40, 32'hA5A5A5A5, 32'h0, 1);
    chk32("t4_rd_kept", bus_if.mem_rd_data, 32'h55556666);

    // Stray vld while idle must be ignored.
    base = valid_cnt;
    spur = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    spur = 1'b0;
    @(posedge clk); #1;
    chk32("spur_pulses", 32'(valid_cnt - base), 32'd0);

    // 5: no response -> timeout, then a normal load keeps bus_err set.
    do_access(1'b1, 1'b0, 32'h50, 32'h0, 32'hFFFFFFFF, 0);
    chk1("t5_bus_err", bus_if.bus_err, 1'b1);
    chk32("t5_rd_zero", bus_if.mem_rd_data, 32'h0);
    chk32("t5_latency", 32'(last_valid_cyc - last_req), 32'd10);
    do_access(1'b1, 1'b0, 32'h54, 32'h0, 32'h0BADF00D, 1);
    chk1("t5_err_sticky", bus_if.bus_err, 1'b1);
    chk32("t5_rd_next", bus_if.mem_rd_data, 32'h0BADF00D);

    // 6: reset during WAIT of a store.
    base     = valid_cnt;
    a_wr     = 1'b1;
    a_addr   = 32'h60;
    a_wdata  = 32'hDEADC0DE;
    a_delay  = 0;
    a_to     = 1'b1;
    a_req    = cyc;
    a_done   = cyc + lat_of(0);
    a_active = 1'b1;
    bus_if.mem_wr      = 1'b1;
    bus_if.mem_addr    = 32'h60;
    bus_if.mem_wr_data = 32'hDEADC0DE;
    repeat (3) begin @(posedge clk); #1; end
    rst      = 1'b1;
    a_active = 1'b0;
    #1;
    chk1("t6_oe", dbg_oe, 1'b0);
    chk32("t6_cpu_rw", 32'(bus_if.cpu_rw), 32'd0);
    chk1("t6_stall", bus_if.stall, 1'b0);
    chk1("t6_valid", bus_if.mem_valid, 1'b0);
    bus_if.mem_wr = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk32("t6_no_pulse", 32'(valid_cnt - base), 32'd0);
    do_access(1'b1, 1'b0, 32'h70, 32'h0, 32'h13579BDF, 1);
    chk32("t6_rd_after", bus_if.mem_rd_data, 32'h13579BDF);
    chk1("t6_err_clear", bus_if.bus_err, 1'b0);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
